// File: rtl/twiddle_seq_ctrl.sv
// Frame sequencer for the twiddle multiplier: checks beat framing, drives `count` alongside din and
// delays {valid,sof,eof,idx} by LATENCY to line up with dout. Never stalls; 1 beat/clk, no backpressure.
module twiddle_seq_ctrl #(
  parameter int BEATS   = 4,
  parameter int LATENCY = 3,
  parameter int TIMEOUT = 15,
  parameter int CW      = $clog2(BEATS)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  input  logic          in_sof,
  output logic [CW-1:0] count,
  output logic          out_valid,
  output logic          out_sof,
  output logic          out_eof,
  output logic [CW-1:0] out_idx,
  output logic          busy,
  output logic          err_sof,
  output logic          err_orphan,
  output logic          err_timeout
);

  localparam int GW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic          vld;
    logic          sof;
    logic          eof;
    logic [CW-1:0] idx;
  } stage_t;

  state_t        state;
  logic [CW-1:0] beat_cnt;
  logic [GW-1:0] gap_cnt;
  stage_t        push;
  stage_t        pipe [LATENCY];

  assign count = (in_valid && in_sof) ? '0 : beat_cnt;
  assign busy  = (state == RUN);

  // A sof always restarts a frame; a plain beat is only accepted inside a running frame.
  always_comb begin
    push = '0;
    if (in_valid) begin
      if (in_sof) begin
        push.vld = 1'b1;
        push.sof = 1'b1;
        push.eof = (BEATS == 1);
      end else if (state == RUN) begin
        push.vld = 1'b1;
        push.eof = (beat_cnt == CW'(BEATS - 1));
        push.idx = beat_cnt;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      gap_cnt     <= '0;
      err_sof     <= 1'b0;
      err_orphan  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_sof     <= 1'b0;
      err_orphan  <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (in_sof) begin
              beat_cnt <= (BEATS == 1) ? '0 : CW'(1);
              gap_cnt  <= '0;
              state    <= (BEATS == 1) ? IDLE : RUN;
            end else begin
              err_orphan <= 1'b1;
            end
          end
        end
        RUN: begin
          if (in_valid) begin
            gap_cnt <= '0;
            if (in_sof) begin
              err_sof  <= 1'b1;
              beat_cnt <= CW'(1);
            end else if (beat_cnt == CW'(BEATS - 1)) begin
              beat_cnt <= '0;
              state    <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + CW'(1);
            end
          end else if (gap_cnt == GW'(TIMEOUT - 1)) begin
            // The idle cycle that brings the gap to TIMEOUT aborts the frame.
            err_timeout <= 1'b1;
            beat_cnt    <= '0;
            gap_cnt     <= '0;
            state       <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The multiplier has no enable, so the side pipe shifts unconditionally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= push;
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign out_valid = pipe[LATENCY-1].vld;
  assign out_sof   = pipe[LATENCY-1].vld & pipe[LATENCY-1].sof;
  assign out_eof   = pipe[LATENCY-1].vld & pipe[LATENCY-1].eof;
  assign out_idx   = pipe[LATENCY-1].vld ? pipe[LATENCY-1].idx : '0;

endmodule

// File: tb/tb_twiddle_seq_ctrl.sv
// Directed bench for twiddle_seq_ctrl: a hand-written vector table plus reset and LATENCY=5 sequences.
module tb_twiddle_seq_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       in_valid;
  logic       in_sof;
  logic [1:0] count, out_idx, count5, out_idx5;
  logic       out_valid, out_sof, out_eof, busy, err_sof, err_orphan, err_timeout;
  logic       out_valid5, out_sof5, out_eof5, busy5, err_sof5, err_orphan5, err_timeout5;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  twiddle_seq_ctrl #(.BEATS(4), .LATENCY(3), .TIMEOUT(15), .CW(2)) u_dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_sof(in_sof), .count(count),
    .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof), .out_idx(out_idx),
    .busy(busy), .err_sof(err_sof), .err_orphan(err_orphan), .err_timeout(err_timeout)
  );

  twiddle_seq_ctrl #(.BEATS(4), .LATENCY(5), .TIMEOUT(15), .CW(2)) u_dut5 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_sof(in_sof), .count(count5),
    .out_valid(out_valid5), .out_sof(out_sof5), .out_eof(out_eof5), .out_idx(out_idx5),
    .busy(busy5), .err_sof(err_sof5), .err_orphan(err_orphan5), .err_timeout(err_timeout5)
  );

  typedef struct {
    logic       v;
    logic       s;
    logic [1:0] cnt;
    logic       ov;
    logic       osof;
    logic       oeof;
    logic [1:0] oidx;
    logic       busy;
    logic [2:0] err;   // {err_sof, err_orphan, err_timeout}
  } vec_t;

  localparam int NROWS = 57;
  vec_t tbl [NROWS];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_in(input int r, input logic v, input logic s, input logic [1:0] cnt, input logic b);
    tbl[r].v    = v;
    tbl[r].s    = s;
    tbl[r].cnt  = cnt;
    tbl[r].busy = b;
  endtask

  task automatic set_out(input int r, input logic sof, input logic eof, input logic [1:0] idx);
    tbl[r].ov   = 1'b1;
    tbl[r].osof = sof;
    tbl[r].oeof = eof;
    tbl[r].oidx = idx;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " out_valid"}, 8'(out_valid), 8'd0);
    chk({tag, " out_sof"}, 8'(out_sof), 8'd0);
    chk({tag, " out_eof"}, 8'(out_eof), 8'd0);
    chk({tag, " out_idx"}, 8'(out_idx), 8'd0);
    chk({tag, " busy"}, 8'(busy), 8'd0);
    chk({tag, " count"}, 8'(count), 8'd0);
    chk({tag, " errs"}, 8'({err_sof, err_orphan, err_timeout}), 8'd0);
  endtask

  initial begin
    for (int r = 0; r < NROWS; r++) tbl[r] = '{default: '0};

    // Three clean back-to-back frames, then flush.
    for (int r = 0; r < 12; r++) begin
      set_in(r, 1'b1, (r % 4) == 0, 2'(r % 4), (r % 4) != 0);
      set_out(r + 3, (r % 4) == 0, (r % 4) == 3, 2'(r % 4));
    end
    // Frame with a 5-cycle gap between beats 1 and 2.
    set_in(15, 1'b1, 1'b1, 2'd0, 1'b0);
    set_in(16, 1'b1, 1'b0, 2'd1, 1'b1);
    for (int r = 17; r < 22; r++) set_in(r, 1'b0, 1'b0, 2'd2, 1'b1);
    set_in(22, 1'b1, 1'b0, 2'd2, 1'b1);
    set_in(23, 1'b1, 1'b0, 2'd3, 1'b1);
    set_out(18, 1'b1, 1'b0, 2'd0);
    set_out(19, 1'b0, 1'b0, 2'd1);
    set_out(25, 1'b0, 1'b0, 2'd2);
    set_out(26, 1'b0, 1'b1, 2'd3);
    // Early sof: sof, beat, sof, beat, beat, beat.
    set_in(27, 1'b1, 1'b1, 2'd0, 1'b0);
    set_in(28, 1'b1, 1'b0, 2'd1, 1'b1);
    set_in(29, 1'b1, 1'b1, 2'd0, 1'b1);
    set_in(30, 1'b1, 1'b0, 2'd1, 1'b1);
    set_in(31, 1'b1, 1'b0, 2'd2, 1'b1);
    set_in(32, 1'b1, 1'b0, 2'd3, 1'b1);
    tbl[30].err = 3'b100;
    set_out(30, 1'b1, 1'b0, 2'd0);
    set_out(31, 1'b0, 1'b0, 2'd1);
    set_out(32, 1'b1, 1'b0, 2'd0);
    set_out(33, 1'b0, 1'b0, 2'd1);
    set_out(34, 1'b0, 1'b0, 2'd2);
    set_out(35, 1'b0, 1'b1, 2'd3);
    // Orphan, then sof + 15 idle cycles (timeout), then another orphan.
    set_in(36, 1'b1, 1'b0, 2'd0, 1'b0);
    tbl[37].err = 3'b010;
    set_in(38, 1'b1, 1'b1, 2'd0, 1'b0);
    for (int r = 39; r < 54; r++) set_in(r, 1'b0, 1'b0, 2'd1, 1'b1);
    set_out(41, 1'b1, 1'b0, 2'd0);
    set_in(54, 1'b1, 1'b0, 2'd0, 1'b0);
    tbl[54].err = 3'b001;
    tbl[55].err = 3'b010;

    rstn = 1'b0;
    in_valid = 1'b0;
    in_sof = 1'b0;
    #12;
    chk_all_zero("reset");
    chk("reset out_valid5", 8'(out_valid5), 8'd0);
    @(negedge clk);
    rstn = 1'b1;

    for (int r = 0; r < NROWS; r++) begin
      @(negedge clk);
      in_valid = tbl[r].v;
      in_sof = tbl[r].s;
      #2;
      chk($sformatf("r%0d count", r), 8'(count), 8'(tbl[r].cnt));
      chk($sformatf("r%0d out_valid", r), 8'(out_valid), 8'(tbl[r].ov));
      chk($sformatf("r%0d out_sof", r), 8'(out_sof), 8'(tbl[r].osof));
      chk($sformatf("r%0d out_eof", r), 8'(out_eof), 8'(tbl[r].oeof));
      chk($sformatf("r%0d out_idx", r), 8'(out_idx), 8'(tbl[r].oidx));
      chk($sformatf("r%0d busy", r), 8'(busy), 8'(tbl[r].busy));
      chk($sformatf("r%0d errs", r), 8'({err_sof, err_orphan, err_timeout}), 8'(tbl[r].err));
    end

    // Reset asserted mid-frame after beat 2: everything clears asynchronously.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_sof = (k == 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_sof = 1'b0;
    #1;
    chk("pre-reset busy", 8'(busy), 8'd1);
    chk("pre-reset out_valid", 8'(out_valid), 8'd1);
    rstn = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      in_valid = (k < 4);
      in_sof = (k == 0);
      #2;
      chk($sformatf("post-rst c%0d count", k), 8'(count), 8'((k < 4) ? k : 0));
      chk($sformatf("post-rst c%0d out_valid", k), 8'(out_valid), 8'(k >= 3 && k < 7));
      chk($sformatf("post-rst c%0d out_sof", k), 8'(out_sof), 8'(k == 3));
      chk($sformatf("post-rst c%0d out_eof", k), 8'(out_eof), 8'(k == 6));
      chk($sformatf("post-rst c%0d out_idx", k), 8'(out_idx), 8'((k >= 3 && k < 7) ? k - 3 : 0));
    end

    // Clean frames seen through the LATENCY=5 instance.
    @(negedge clk);
    rstn = 1'b0;
    #1;
    rstn = 1'b1;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      in_valid = (c < 12);
      in_sof = (c < 12) && (c % 4 == 0);
      #2;
      chk($sformatf("lat5 c%0d out_valid", c), 8'(out_valid5), 8'(c >= 5 && c < 17));
      chk($sformatf("lat5 c%0d out_sof", c), 8'(out_sof5), 8'(c == 5 || c == 9 || c == 13));
      chk($sformatf("lat5 c%0d out_eof", c), 8'(out_eof5), 8'(c == 8 || c == 12 || c == 16));
      chk($sformatf("lat3 c%0d out_valid", c), 8'(out_valid), 8'(c >= 3 && c < 15));
    end

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
